// File: rtl/updown_counter_n.sv
// Modulo-N up/down counter with parallel load, registered Gray output and wrap pulse.
// Define UPDOWN_COUNTER_N_SAT_EN to saturate at the ends instead of wrapping.
module updown_counter_n #(
  parameter int WIDTH  = 3,
  parameter int MODULO = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_g,
  output logic             o_tc,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_g;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_load;
  logic             w_wrap_next;
  logic             w_at_top;
  logic             w_at_bot;

  assign w_at_top = (r_q == MAX_Q);
  assign w_at_bot = (r_q == '0);

  // Extra MSB lets MODULO == 2**WIDTH compare correctly (no load value clamps).
  assign w_load = ({1'b0, i_d} >= MOD_EXT) ? MAX_Q : i_d;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (i_ld) begin
      w_q_next = w_load;
    end else if (i_en) begin
      if (i_dir) begin
        if (w_at_top) begin
`ifdef UPDOWN_COUNTER_N_SAT_EN
          w_q_next = r_q;
`else
          w_q_next    = '0;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_q_next = r_q + 1'b1;
        end
      end else begin
        if (w_at_bot) begin
`ifdef UPDOWN_COUNTER_N_SAT_EN
          w_q_next = r_q;
`else
          w_q_next    = MAX_Q;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_q_next = r_q - 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_g    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_g    <= w_q_next ^ (w_q_next >> 1);
      r_wrap <= w_wrap_next;
    end
  end

  assign o_q    = r_q;
  assign o_g    = r_g;
  assign o_wrap = r_wrap;
  assign o_tc   = i_dir ? w_at_top : w_at_bot;

endmodule
